// File: rtl/sprite_fetch_pkg.sv
// Shared types and constants for the sprite table fetch adapter.
package sprite_fetch_pkg;
   localparam int LINE_BYTES  = 8;
   localparam int BURST_WORDS = 4;
   localparam int WORD_W      = 16;
   localparam int LINE_W      = LINE_BYTES * 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIT,
      ST_FETCH_REQ,
      ST_FETCH_DATA
   } state_e;

   typedef enum logic {
      K_DEMAND,
      K_PF
   } kind_e;
endpackage

// File: rtl/sprite_table_fetch_if.sv
// Copy-engine fetch port plus the 16-bit SDRAM channel, bundled for the adapter.
interface sprite_table_fetch_if #(
   parameter int ADDR_W = 25
);
   logic              req;
   logic [ADDR_W-1:0] req_addr;
   logic [63:0]       data_out;
   logic              rdy;
   logic              busy;
   logic              inval;
   logic [ADDR_W-1:0] ch_addr;
   logic              ch_req;
   logic              ch_ack;
   logic [15:0]       ch_data;
   logic              ch_valid;

   modport slave (
      input  req, req_addr, inval, ch_ack, ch_data, ch_valid,
      output data_out, rdy, busy, ch_addr, ch_req
   );

   modport master (
      output req, req_addr, inval, ch_ack, ch_data, ch_valid,
      input  data_out, rdy, busy, ch_addr, ch_req
   );
endinterface

// File: rtl/sprite_fetch_packer.sv
// Collects a 4-word SDRAM burst into one line; word0 lands in the low 16 bits.
import sprite_fetch_pkg::*;

module sprite_fetch_packer (
   input  logic              clk_ram,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              strobe_i,
   input  logic [WORD_W-1:0] word_i,
   output logic [LINE_W-1:0] line_o,
   output logic              done_o
);
   logic [1:0]        cnt_q, cnt_d;
   logic [LINE_W-1:0] sh_q, sh_d;

   // Shift right so the first word ends up at the bottom after the last strobe.
   always_comb begin
      cnt_d = cnt_q;
      sh_d  = sh_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (strobe_i) begin
         cnt_d = cnt_q + 2'd1;
         sh_d  = {word_i, sh_q[LINE_W-1:WORD_W]};
      end
   end

   always_ff @(posedge clk_ram) begin
      if (reset) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
      end
   end

   assign line_o = {word_i, sh_q[LINE_W-1:WORD_W]};
   assign done_o = strobe_i && (cnt_q == 2'(BURST_WORDS - 1));
endmodule

// File: rtl/sprite_table_fetch.sv
// Sprite-list fetch adapter: 64-bit line reads over a 16-bit SDRAM channel,
// with a one-line speculative prefetch of the next sequential line.
import sprite_fetch_pkg::*;

module sprite_table_fetch #(
   parameter int ADDR_W   = 25,
   parameter bit PREFETCH = 1'b1
) (
   input logic                  clk_ram,
   input logic                  reset,
   sprite_table_fetch_if.slave  bus
);
   localparam logic [ADDR_W-1:0] LINE_INC  = ADDR_W'(LINE_BYTES);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

   state_e              state_q, state_d;
   kind_e               kind_q, kind_d;
   logic                req_q;
   logic                pending_q, pending_d;
   logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
   logic [ADDR_W-1:0]   ch_addr_q, ch_addr_d;
   logic                pf_valid_q, pf_valid_d;
   logic [ADDR_W-1:0]   pf_tag_q, pf_tag_d;
   logic [LINE_W-1:0]   pf_line_q, pf_line_d;
   logic                discard_q, discard_d;
   logic [LINE_W-1:0]   data_q, data_d;
   logic                rdy_q, rdy_d;

   logic                new_req, hit_ok, pk_clear, pk_strobe, pk_done;
   logic [LINE_W-1:0]   pk_line;

   assign new_req   = bus.req && !req_q;
   assign hit_ok    = pf_valid_q && !bus.inval && (pf_tag_q == pend_addr_q);
   assign pk_clear  = (state_q == ST_FETCH_REQ) && bus.ch_ack;
   assign pk_strobe = (state_q == ST_FETCH_DATA) && bus.ch_valid;

   sprite_fetch_packer u_pack (
      .clk_ram  (clk_ram),
      .reset    (reset),
      .clear_i  (pk_clear),
      .strobe_i (pk_strobe),
      .word_i   (bus.ch_data),
      .line_o   (pk_line),
      .done_o   (pk_done)
   );

   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      pending_d   = pending_q;
      pend_addr_d = pend_addr_q;
      ch_addr_d   = ch_addr_q;
      pf_valid_d  = pf_valid_q;
      pf_tag_d    = pf_tag_q;
      pf_line_d   = pf_line_q;
      discard_d   = discard_q;
      data_d      = data_q;
      rdy_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pending_q) begin
               if (hit_ok) begin
                  state_d    = ST_HIT;
                  data_d     = pf_line_q;
                  rdy_d      = 1'b1;
                  pending_d  = 1'b0;
                  pf_valid_d = 1'b0;
               end else begin
                  state_d   = ST_FETCH_REQ;
                  kind_d    = K_DEMAND;
                  ch_addr_d = pend_addr_q;
                  discard_d = 1'b0;
               end
            end
         end
         ST_HIT: begin
            if (PREFETCH) begin
               state_d   = ST_FETCH_REQ;
               kind_d    = K_PF;
               ch_addr_d = pf_tag_q + LINE_INC;
               discard_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH_REQ: begin
            if (bus.ch_ack) begin
               state_d = ST_FETCH_DATA;
            end else if (kind_q == K_PF && pending_q && pend_addr_q != ch_addr_q) begin
               // Burst not yet accepted, so it can be retargeted to the real request.
               kind_d    = K_DEMAND;
               ch_addr_d = pend_addr_q;
            end
         end
         ST_FETCH_DATA: begin
            if (pk_done) begin
               if (kind_q == K_DEMAND) begin
                  data_d    = pk_line;
                  rdy_d     = 1'b1;
                  pending_d = 1'b0;
                  if (PREFETCH) begin
                     state_d   = ST_FETCH_REQ;
                     kind_d    = K_PF;
                     ch_addr_d = ch_addr_q + LINE_INC;
                     discard_d = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else if (discard_q || bus.inval) begin
                  state_d = ST_IDLE;
               end else begin
                  pf_line_d  = pk_line;
                  pf_tag_d   = ch_addr_q;
                  pf_valid_d = 1'b1;
                  if (pending_q && pend_addr_q == ch_addr_q) begin
                     state_d    = ST_HIT;
                     data_d     = pk_line;
                     rdy_d      = 1'b1;
                     pending_d  = 1'b0;
                     pf_valid_d = 1'b0;
                  end else if (pending_q) begin
                     state_d   = ST_FETCH_REQ;
                     kind_d    = K_DEMAND;
                     ch_addr_d = pend_addr_q;
                     discard_d = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (bus.inval) begin
         pf_valid_d = 1'b0;
         if (kind_q == K_PF && (state_q == ST_FETCH_REQ || state_q == ST_FETCH_DATA))
            discard_d = 1'b1;
      end

      if (new_req) begin
         pending_d   = 1'b1;
         pend_addr_d = bus.req_addr & LINE_MASK;
      end
   end

   always_ff @(posedge clk_ram) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         kind_q      <= K_DEMAND;
         req_q       <= 1'b0;
         pending_q   <= 1'b0;
         pend_addr_q <= '0;
         ch_addr_q   <= '0;
         pf_valid_q  <= 1'b0;
         pf_tag_q    <= '0;
         pf_line_q   <= '0;
         discard_q   <= 1'b0;
         data_q      <= '0;
         rdy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         req_q       <= bus.req;
         pending_q   <= pending_d;
         pend_addr_q <= pend_addr_d;
         ch_addr_q   <= ch_addr_d;
         pf_valid_q  <= pf_valid_d;
         pf_tag_q    <= pf_tag_d;
         pf_line_q   <= pf_line_d;
         discard_q   <= discard_d;
         data_q      <= data_d;
         rdy_q       <= rdy_d;
      end
   end

   assign bus.data_out = data_q;
   assign bus.rdy      = rdy_q;
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.ch_req   = (state_q == ST_FETCH_REQ);
   assign bus.ch_addr  = ch_addr_q;
endmodule
